alu_issue_stage: RTL and testbench

//  Issue stage directly upstream of the integer ALU. Buffers decoded ALU ops from decode
//  (valid/ready) in a 2-entry FIFO and selects operands: rs data, PC, zero or immediate.

---
 rtl/alu_issue_stage.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the integer ALU: a 2-entry op FIFO, operand select and EX/WB forwarding.
// Define ISSUE_PERF_EN to add the o_perf_issued / o_perf_stall counters.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [9:0]      s_funct,
  input  logic [4:0]      s_rd,
  input  logic [4:0]      s_rs1,
  input  logic [4:0]      s_rs2,
  input  logic [XLEN-1:0] s_rs1_data,
  input  logic [XLEN-1:0] s_rs2_data,
  input  logic [XLEN-1:0] s_imm,
  input  logic [XLEN-1:0] s_pc,
  input  logic [1:0]      s_src1_sel,
  input  logic            s_src2_sel,
  input  logic            i_stall,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_alu_en,
  output logic [9:0]      o_alu_funct,
  output logic [XLEN-1:0] o_alu_src1,
  output logic [XLEN-1:0] o_alu_src2,
`ifdef ISSUE_PERF_EN
  output logic [31:0]     o_perf_issued,
  output logic [31:0]     o_perf_stall,
`endif
  output logic            o_ex_valid,
  output logic [4:0]      o_ex_rd
);

  typedef struct packed {
    logic [9:0]      funct;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [1:0]      src1_sel;
    logic            src2_sel;
  } entry_t;

  entry_t          entries [DEPTH];
  entry_t          push_entry;
  entry_t          head;
  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] rs1_res;
  logic [XLEN-1:0] rs2_res;

  // EX result beats WB; x0 always reads as zero regardless of stored data.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] stored,
    input logic            ex_v,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_v,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (rs == 5'd0)                   return '0;
    else if (ex_v && ex_rd == rs)     return ex_data;
    else if (wb_v && wb_rd == rs)     return wb_data;
    else                              return stored;
  endfunction

  assign s_ready  = (count != 2'd2);
  assign o_alu_en = (count != 2'd0);
  assign push     = s_valid && s_ready;
  assign pop      = o_alu_en && !i_stall;

  always_comb begin
    push_entry          = '0;
    push_entry.funct    = s_funct;
    push_entry.rd       = s_rd;
    push_entry.rs1      = s_rs1;
    push_entry.rs2      = s_rs2;
    push_entry.imm      = s_imm;
    push_entry.pc       = s_pc;
    push_entry.src1_sel = s_src1_sel;
    push_entry.src2_sel = s_src2_sel;
    push_entry.rs1_data = (i_wb_valid && s_rs1 != 5'd0 && i_wb_rd == s_rs1) ? i_wb_data : s_rs1_data;
    push_entry.rs2_data = (i_wb_valid && s_rs2 != 5'd0 && i_wb_rd == s_rs2) ? i_wb_data : s_rs2_data;
  end

  // Head is zeroed while empty so funct/src outputs read 0.
  always_comb begin
    head = '0;
    if (o_alu_en) head = entries[rd_ptr];
    rs1_res = resolve(head.rs1, head.rs1_data, o_ex_valid, o_ex_rd, i_alu_res,
                      i_wb_valid, i_wb_rd, i_wb_data);
    rs2_res = resolve(head.rs2, head.rs2_data, o_ex_valid, o_ex_rd, i_alu_res,
                      i_wb_valid, i_wb_rd, i_wb_data);
    o_alu_funct = head.funct;
    case (head.src1_sel)
      2'd0:    o_alu_src1 = rs1_res;
      2'd1:    o_alu_src1 = head.pc;
      default: o_alu_src1 = '0;
    endcase
    o_alu_src2 = head.src2_sel ? head.imm : rs2_res;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      o_ex_valid <= 1'b0;
      o_ex_rd    <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      // Snoop writeback so waiting entries never hold stale register values.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wb_valid && entries[i].rs1 != 5'd0 && entries[i].rs1 == i_wb_rd)
          entries[i].rs1_data <= i_wb_data;
        if (i_wb_valid && entries[i].rs2 != 5'd0 && entries[i].rs2 == i_wb_rd)
          entries[i].rs2_data <= i_wb_data;
      end
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop) begin
        o_ex_valid <= 1'b1;
        o_ex_rd    <= head.rd;
      end else if (!i_stall) begin
        o_ex_valid <= 1'b0;
      end
    end
  end

`ifdef ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_perf_issued <= '0;
      o_perf_stall  <= '0;
    end else begin
      if (pop)                  o_perf_issued <= o_perf_issued + 32'd1;
      if (o_alu_en && i_stall)  o_perf_stall  <= o_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; checks perf counters when ISSUE_PERF_EN is defined.
module tb_alu_issue_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic            s_valid;
  logic            s_ready;
  logic [9:0]      s_funct;
  logic [4:0]      s_rd, s_rs1, s_rs2;
  logic [XLEN-1:0] s_rs1_data, s_rs2_data, s_imm, s_pc;
  logic [1:0]      s_src1_sel;
  logic            s_src2_sel;
  logic            i_stall;
  logic [XLEN-1:0] i_alu_res;
  logic            i_wb_valid;
  logic [4:0]      i_wb_rd;
  logic [XLEN-1:0] i_wb_data;
  logic            o_alu_en;
  logic [9:0]      o_alu_funct;
  logic [XLEN-1:0] o_alu_src1, o_alu_src2;
  logic            o_ex_valid;
  logic [4:0]      o_ex_rd;
`ifdef ISSUE_PERF_EN
  logic [31:0]     o_perf_issued, o_perf_stall;
  logic [31:0]     base_issued, base_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(XLEN), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_funct(s_funct), .s_rd(s_rd),
    .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rs1_data(s_rs1_data), .s_rs2_data(s_rs2_data),
    .s_imm(s_imm), .s_pc(s_pc), .s_src1_sel(s_src1_sel), .s_src2_sel(s_src2_sel),
    .i_stall(i_stall), .i_alu_res(i_alu_res),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_alu_en(o_alu_en), .o_alu_funct(o_alu_funct),
    .o_alu_src1(o_alu_src1), .o_alu_src2(o_alu_src2),
`ifdef ISSUE_PERF_EN
    .o_perf_issued(o_perf_issued), .o_perf_stall(o_perf_stall),
`endif
    .o_ex_valid(o_ex_valid), .o_ex_rd(o_ex_rd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [9:0] f, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [1:0] sel1, input logic sel2);
    s_valid = v;  s_funct = f;  s_rd = rd;  s_rs1 = rs1;  s_rs2 = rs2;
    s_rs1_data = d1;  s_rs2_data = d2;  s_imm = imm;  s_pc = pc;
    s_src1_sel = sel1;  s_src2_sel = sel2;
  endtask

  task automatic noPush();
    applyStimulus(1'b0, 10'h000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic setWb(input logic v, input logic [4:0] rd, input logic [31:0] data);
    i_wb_valid = v;  i_wb_rd = rd;  i_wb_data = data;
  endtask

  // Drive for the cycle, then let combinational outputs settle before checking.
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;  i_stall = 1'b0;  i_alu_res = '0;
    noPush();
    setWb(1'b0, 5'd0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // 1: reset state and idle
    for (int i = 0; i < 10; i++) begin
      settle();
      checkOutput("idle_s_ready", 32'(s_ready), 32'd1);
      checkOutput("idle_alu_en", 32'(o_alu_en), 32'd0);
      checkOutput("idle_ex_valid", 32'(o_ex_valid), 32'd0);
      tick();
    end
    checkOutput("idle_ex_rd", 32'(o_ex_rd), 32'd0);
    checkOutput("idle_funct", 32'(o_alu_funct), 32'd0);
    checkOutput("idle_src1", o_alu_src1, 32'd0);

    // 2: single ADD x3,x1,x2
    applyStimulus(1'b1, 10'h000, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 32'h0, 2'd0, 1'b0);
    settle();
    checkOutput("s2_ready", 32'(s_ready), 32'd1);
    tick();
    noPush();
    settle();
    checkOutput("s2_alu_en", 32'(o_alu_en), 32'd1);
    checkOutput("s2_funct", 32'(o_alu_funct), 32'h000);
    checkOutput("s2_src1", o_alu_src1, 32'd5);
    checkOutput("s2_src2", o_alu_src2, 32'd7);
    tick();
    settle();
    checkOutput("s2_ex_valid", 32'(o_ex_valid), 32'd1);
    checkOutput("s2_ex_rd", 32'(o_ex_rd), 32'd3);
    checkOutput("s2_drained", 32'(o_alu_en), 32'd0);
    tick();
    checkOutput("s2_ex_clear", 32'(o_ex_valid), 32'd0);

    // 3: back-to-back ADD x3 then SUB x4,x3,x2 with EX forward
    applyStimulus(1'b1, 10'h000, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 32'h0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 10'h100, 5'd4, 5'd3, 5'd2, 32'd0, 32'd7, 32'h0, 32'h0, 2'd0, 1'b0);
    settle();
    checkOutput("s3_add_src1", o_alu_src1, 32'd5);
    tick();
    noPush();
    i_alu_res = 32'd12;
    settle();
    checkOutput("s3_ex_rd", 32'(o_ex_rd), 32'd3);
    checkOutput("s3_sub_funct", 32'(o_alu_funct), 32'h100);
    checkOutput("s3_sub_src1_fwd", o_alu_src1, 32'd12);
    checkOutput("s3_sub_src2", o_alu_src2, 32'd7);
    tick();
    i_alu_res = '0;
    settle();
    checkOutput("s3_ex_rd_sub", 32'(o_ex_rd), 32'd4);
    tick();

    // 4: stall held 3 cycles with 3 pushes
    applyStimulus(1'b1, 10'h000, 5'd9, 5'd1, 5'd2, 32'd1, 32'd1, 32'h0, 32'h0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 10'h000, 5'd6, 5'd1, 5'd2, 32'h10, 32'h20, 32'h0, 32'h0, 2'd0, 1'b0);
    tick();
    i_stall = 1'b1;
    applyStimulus(1'b1, 10'h100, 5'd7, 5'd1, 5'd2, 32'h30, 32'h40, 32'h0, 32'h0, 2'd0, 1'b0);
    settle();
`ifdef ISSUE_PERF_EN
    base_issued = o_perf_issued;
    base_stall  = o_perf_stall;
`endif
    checkOutput("s4_ex_rd_opA", 32'(o_ex_rd), 32'd9);
    checkOutput("s4_ready_1", 32'(s_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 10'h002, 5'd8, 5'd1, 5'd2, 32'h50, 32'h60, 32'h0, 32'h0, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      settle();
      checkOutput("s4_full_ready", 32'(s_ready), 32'd0);
      checkOutput("s4_held_ex_valid", 32'(o_ex_valid), 32'd1);
      checkOutput("s4_held_ex_rd", 32'(o_ex_rd), 32'd9);
      checkOutput("s4_head_src1", o_alu_src1, 32'h10);
      tick();
    end
    i_stall = 1'b0;
    settle();
    checkOutput("s4_release_ex_rd", 32'(o_ex_rd), 32'd9);
    checkOutput("s4_op1_src2", o_alu_src2, 32'h20);
`ifdef ISSUE_PERF_EN
    checkOutput("s4_perf_stall", o_perf_stall - base_stall, 32'd3);
`endif
    tick();
    settle();
    checkOutput("s4_ex_rd_op1", 32'(o_ex_rd), 32'd6);
    checkOutput("s4_op2_funct", 32'(o_alu_funct), 32'h100);
    checkOutput("s4_op2_src1", o_alu_src1, 32'h30);
    checkOutput("s4_op3_accept", 32'(s_ready), 32'd1);
    tick();
    noPush();
    settle();
    checkOutput("s4_ex_rd_op2", 32'(o_ex_rd), 32'd7);
    checkOutput("s4_op3_funct", 32'(o_alu_funct), 32'h002);
    checkOutput("s4_op3_src2", o_alu_src2, 32'h60);
    tick();
    checkOutput("s4_ex_rd_op3", 32'(o_ex_rd), 32'd8);
    checkOutput("s4_empty", 32'(o_alu_en), 32'd0);
`ifdef ISSUE_PERF_EN
    checkOutput("s4_perf_issued", o_perf_issued - base_issued, 32'd3);
`endif
    tick();

    // 5: WB snoop of a waiting entry, and WB capture at push
    i_stall = 1'b1;
    applyStimulus(1'b1, 10'h000, 5'd10, 5'd5, 5'd2, 32'd0, 32'd7, 32'h0, 32'h0, 2'd0, 1'b0);
    tick();
    noPush();
    setWb(1'b1, 5'd5, 32'hDEAD_BEEF);
    settle();
    checkOutput("s5_wb_fwd", o_alu_src1, 32'hDEAD_BEEF);
    tick();
    setWb(1'b0, 5'd0, 32'h0);
    i_stall = 1'b0;
    settle();
    checkOutput("s5_snooped_src1", o_alu_src1, 32'hDEAD_BEEF);
    checkOutput("s5_src2", o_alu_src2, 32'd7);
    tick();
    i_stall = 1'b1;
    applyStimulus(1'b1, 10'h100, 5'd11, 5'd0, 5'd5, 32'd0, 32'h111, 32'h0, 32'h0, 2'd0, 1'b0);
    setWb(1'b1, 5'd5, 32'h0000_CAFE);
    tick();
    noPush();
    setWb(1'b0, 5'd0, 32'h0);
    i_stall = 1'b0;
    settle();
    checkOutput("s5_push_capture", o_alu_src2, 32'h0000_CAFE);
    checkOutput("s5_x0_src1", o_alu_src1, 32'd0);
    checkOutput("s5_ex_rd_held", 32'(o_ex_rd), 32'd10);
    tick();

    // 6: x0 never forwarded; PC and immediate selects
    applyStimulus(1'b1, 10'h000, 5'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 32'h0, 2'd0, 1'b0);
    tick();
    noPush();
    tick();
    i_stall = 1'b1;
    applyStimulus(1'b1, 10'h000, 5'd15, 5'd0, 5'd0, 32'h5555, 32'h6666, 32'h0, 32'h0, 2'd0, 1'b0);
    i_alu_res = 32'h1234;
    setWb(1'b1, 5'd0, 32'h1234);
    settle();
    checkOutput("s6_ex_valid_x0", 32'(o_ex_valid), 32'd1);
    checkOutput("s6_ex_rd_x0", 32'(o_ex_rd), 32'd0);
    tick();
    applyStimulus(1'b1, 10'h105, 5'd12, 5'd1, 5'd2, 32'd5, 32'd7, 32'h44, 32'h100, 2'd1, 1'b1);
    settle();
    checkOutput("s6_x0_src1", o_alu_src1, 32'd0);
    checkOutput("s6_x0_src2", o_alu_src2, 32'd0);
    tick();
    noPush();
    i_stall = 1'b0;
    i_alu_res = '0;
    setWb(1'b0, 5'd0, 32'h0);
    settle();
    checkOutput("s6_x0_src1_issue", o_alu_src1, 32'd0);
    tick();
    settle();
    checkOutput("s6_pc_funct", 32'(o_alu_funct), 32'h105);
    checkOutput("s6_pc_src1", o_alu_src1, 32'h100);
    checkOutput("s6_imm_src2", o_alu_src2, 32'h44);
    checkOutput("s6_ex_rd", 32'(o_ex_rd), 32'd15);
    tick();
    checkOutput("s6_ex_rd_pc", 32'(o_ex_rd), 32'd12);
    checkOutput("s6_empty_funct", 32'(o_alu_funct), 32'd0);

    // Reset mid-operation drops buffered ops and the EX tag
    i_stall = 1'b1;
    applyStimulus(1'b1, 10'h000, 5'd13, 5'd1, 5'd2, 32'd1, 32'd2, 32'h0, 32'h0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 10'h000, 5'd14, 5'd1, 5'd2, 32'd3, 32'd4, 32'h0, 32'h0, 2'd0, 1'b0);
    tick();
    noPush();
    settle();
    checkOutput("rst_pre_full", 32'(s_ready), 32'd0);
    checkOutput("rst_pre_ex_rd", 32'(o_ex_rd), 32'd12);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    i_stall = 1'b0;
    settle();
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_alu_en", 32'(o_alu_en), 32'd0);
    checkOutput("rst_ex_valid", 32'(o_ex_valid), 32'd0);
    checkOutput("rst_ex_rd", 32'(o_ex_rd), 32'd0);
    checkOutput("rst_funct", 32'(o_alu_funct), 32'd0);
    tick();
    checkOutput("rst_stays_empty", 32'(o_alu_en), 32'd0);
    checkOutput("rst_ex_stays_clear", 32'(o_ex_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
